store_rmw_unit: RTL and testbench
=================================

// Module: store_rmw_unit
// PURPOSE
//  Sequential writer for the data memory: performs SD/SW/SH/SB stores into a 64-bit-wide
//  doubleword memory. Partial stores use a read-modify-write. Counterpart of the load
//  splicer: the control unit issues a splice_store op, this block owns the memory port
//  until done. Sits between the control FSM / register B and the data memory.
// PARAMETERS
//  ADDR_W       64  byte-address width; memory is indexed by addr[ADDR_W-1:3]
//  RD_LATENCY   1   cycles from mem_re to valid mem_rdata (>=1)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset_n      in   1       async active-low reset
//  start        in   1       request; accepted only when busy==0
//  store_op     in   2       splice_store code: SPL_SD/SPL_SW/SPL_SH/SPL_SB
//  addr         in   ADDR_W  byte address of store
//  wdata        in   64      source register; low 8/16/32/64 bits used
//  busy         out  1       high from accept cycle+1 until DONE/ERR exits
//  done         out  1       1-cycle pulse: store committed
//  misaligned   out  1       1-cycle pulse: request rejected, memory untouched
//  mem_addr     out  ADDR_W-3 doubleword index to memory
//  mem_re       out  1       read strobe (1 cycle)
//  mem_rdata    in   64      read data, valid RD_LATENCY cycles after mem_re
//  mem_we       out  1       write strobe (1 cycle)
//  mem_wdata    out  64      merged doubleword
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, misaligned, mem_re, mem_we = 0; mem_addr, mem_wdata = 0.
//    Async assertion mid-operation drops mem_we/mem_re immediately; the pending store is lost.
//  - Accept (IDLE & start): latch store_op, addr[2:0], dword index, wdata. start is ignored
//    while busy; inputs may change after accept.
//  - Alignment: SD off==0; SW off in {0,4}; SH off even; SB any. Violation -> ERR.
//  - FSM: IDLE -> ERR (misaligned) | WRITE (SPL_SD) | READ (partial)
//    READ: mem_re=1, mem_addr=index -> WAIT
//    WAIT: count RD_LATENCY-1 further cycles; on the cycle mem_rdata is valid, capture it -> MERGE
//    MERGE: mem_wdata = rdata with lane [8*off +: size] replaced by wdata[size-1:0] -> WRITE
//    WRITE: mem_we=1 one cycle, mem_addr=index -> DONE
//    DONE: done=1 one cycle -> IDLE;  ERR: misaligned=1 one cycle -> IDLE
//  - Latency, accept->done pulse: SD 2 cycles; partial 4+RD_LATENCY cycles.
//  - mem_re and mem_we are never high in the same cycle. mem_addr holds the latched index
//    throughout READ..WRITE.
//  - Back-to-back: start asserted in the DONE cycle is ignored; it is accepted in the
//    following IDLE cycle.
//  - Bytes outside the target lane are written back bit-exact from mem_rdata.
//  - Little-endian: byte k of the doubleword = bits [8k+7:8k].
// STRUCTURE
//  - package operations: reuse splice_store. Add the state enum
//    {ST_IDLE, ST_READ, ST_WAIT, ST_MERGE, ST_WRITE, ST_DONE, ST_ERR} store_rmw_state.
//    Add the _CAUSE_MISALIGNED_ST entry to mux_Cause.
//  - Sub-module store_lane_merge (combinational): (old[63:0], new[63:0], op, off) -> merged[63:0].
//    Also drives the misaligned flag. Shared by the FSM MERGE stage and the bench model.
//  - Latency counter: clog2(RD_LATENCY+1) bits, cleared on entry to WAIT.
// TESTING
//  - SD addr=0x10, wdata=0x1122334455667788 -> no mem_re; mem_we at accept+1 idx=2, data as given; done at +2.
//  - SB addr=0x0B, mem word 0xFFFF..FF, wdata=0xAB -> write 0xFFFFFFFFABFFFFFF idx=1; done at +5 (RD_LATENCY=1).
//  - SW addr=0x4 -> upper word replaced; SW addr=0x2 -> misaligned pulse, no mem_re/mem_we, busy drops next cycle.
//  - SH at offset 6 with RD_LATENCY=3 -> mem_rdata captured on the 3rd cycle after mem_re; bits[63:48]=wdata[15:0].
//  - start held high through a store -> exactly one store committed per accept; second accepted only after DONE.
//  - reset_n low during WAIT -> mem_we stays 0, outputs zeroed; after release a fresh SB completes normally.

Source files
------------

// File: rtl/store_rmw_unit_pkg.sv
// Shared types for the store read-modify-write path: splice codes, FSM states,
// exception causes and the latched store request payload.
package store_rmw_unit_pkg;

  localparam int unsigned DW    = 64;
  localparam int unsigned OFF_W = 3;

  typedef enum logic [1:0] {
    SPL_SD = 2'd0,
    SPL_SW = 2'd1,
    SPL_SH = 2'd2,
    SPL_SB = 2'd3
  } splice_store;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_MERGE,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } store_rmw_state;

  typedef enum logic [1:0] {
    _CAUSE_NONE,
    _CAUSE_MISALIGNED_LD,
    _CAUSE_MISALIGNED_ST
  } mux_Cause;

  // Store request as held for the whole operation; the dword index lives in mem_addr.
  typedef struct packed {
    splice_store      op;
    logic [OFF_W-1:0] off;
    logic [DW-1:0]    data;
  } store_req_t;

  // Lane footprint of a store, one bit per byte starting at offset 0.
  function automatic logic [7:0] lane_size_mask(input splice_store op);
    case (op)
      SPL_SD:  return 8'hFF;
      SPL_SW:  return 8'h0F;
      SPL_SH:  return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/store_rmw_unit_lane_merge.sv
// Combinational lane splice: replaces the addressed byte lane of a doubleword
// with the low bytes of the source register and flags misaligned requests.
module store_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [DW-1:0]    old_dw,
  input  logic [DW-1:0]    new_dw,
  input  splice_store      op,
  input  logic [OFF_W-1:0] off,
  output logic [DW-1:0]    merged_c,
  output logic             misaligned_c
);

  logic [7:0]    byte_en;
  logic [DW-1:0] bit_en;
  logic [DW-1:0] shifted;

  always_comb begin
    misaligned_c = 1'b0;
    bit_en       = '0;
    case (op)
      SPL_SD:  misaligned_c = (off != 3'd0);
      SPL_SW:  misaligned_c = (off[1:0] != 2'd0);
      SPL_SH:  misaligned_c = off[0];
      default: misaligned_c = 1'b0;
    endcase
    // Aligned requests never carry the mask past byte 7.
    byte_en = lane_size_mask(op) << off;
    for (int k = 0; k < 8; k++) begin
      bit_en[8*k +: 8] = {8{byte_en[k]}};
    end
    shifted  = new_dw << {off, 3'b000};
    merged_c = (old_dw & ~bit_en) | (shifted & bit_en);
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Sequential store engine for the 64-bit data memory: full doubleword stores
// write directly, narrower stores read the word, splice the lane and write back.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        store_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-4:0] mem_addr,
  output logic              mem_re,
  input  logic [63:0]       mem_rdata,
  output logic              mem_we,
  output logic [63:0]       mem_wdata
);

  localparam int unsigned IDX_W = ADDR_W - 3;
  localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  store_rmw_state   state_q, state_n;
  store_req_t       req_q, req_n;
  logic [DW-1:0]    rdata_q, rdata_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             busy_n, done_n, misaligned_n, mem_re_n, mem_we_n;
  logic [IDX_W-1:0] mem_addr_n;
  logic [DW-1:0]    mem_wdata_n;

  logic             idle;
  splice_store      mrg_op;
  logic [OFF_W-1:0] mrg_off;
  logic [DW-1:0]    mrg_new;
  logic [DW-1:0]    merged_c;
  logic             misaligned_c;

  // In IDLE the splicer checks the incoming request; afterwards it works on the latched one.
  always_comb begin
    idle    = (state_q == ST_IDLE);
    mrg_op  = idle ? splice_store'(store_op) : req_q.op;
    mrg_off = idle ? addr[2:0] : req_q.off;
    mrg_new = idle ? wdata : req_q.data;
  end

  store_lane_merge u_lane_merge (
    .old_dw       (rdata_q),
    .new_dw       (mrg_new),
    .op           (mrg_op),
    .off          (mrg_off),
    .merged_c     (merged_c),
    .misaligned_c (misaligned_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_n;
      req_q      <= req_n;
      rdata_q    <= rdata_n;
      cnt_q      <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      misaligned <= misaligned_n;
      mem_re     <= mem_re_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
    end
  end

  // Strobes are registered, so each is raised on the transition into its state.
  always_comb begin
    state_n      = state_q;
    req_n        = req_q;
    rdata_n      = rdata_q;
    cnt_n        = cnt_q;
    done_n       = 1'b0;
    misaligned_n = 1'b0;
    mem_re_n     = 1'b0;
    mem_we_n     = 1'b0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_n.op   = splice_store'(store_op);
          req_n.off  = addr[2:0];
          req_n.data = wdata;
          if (misaligned_c) begin
            state_n      = ST_ERR;
            misaligned_n = 1'b1;
          end else begin
            mem_addr_n = addr[ADDR_W-1:3];
            if (splice_store'(store_op) == SPL_SD) begin
              state_n     = ST_WRITE;
              mem_we_n    = 1'b1;
              mem_wdata_n = merged_c;
            end else begin
              state_n  = ST_READ;
              mem_re_n = 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        state_n = ST_WAIT;
        cnt_n   = '0;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_n = mem_rdata;
          state_n = ST_MERGE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_MERGE: begin
        mem_wdata_n = merged_c;
        mem_we_n    = 1'b1;
        state_n     = ST_WRITE;
      end
      ST_WRITE: begin
        done_n  = 1'b1;
        state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: two instances (read latency 1 and 3) share stimulus,
// each with its own memory model; results are compared to a byte-level store model.
module tb_store_rmw_unit;
  import store_rmw_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  store_op = 2'd0;
  logic [63:0] addr = 64'd0;
  logic [63:0] wdata = 64'd0;

  logic [1:0]  busy_w, done_w, mis_w, mem_re_w, mem_we_w;
  logic [60:0] mem_addr_w [2];
  logic [63:0] mem_rdata_w [2];
  logic [63:0] mem_wdata_w [2];

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    store_rmw_unit #(.ADDR_W(64), .RD_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .store_op   (store_op),
      .addr       (addr),
      .wdata      (wdata),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .misaligned (mis_w[g]),
      .mem_addr   (mem_addr_w[g]),
      .mem_re     (mem_re_w[g]),
      .mem_rdata  (mem_rdata_w[g]),
      .mem_we     (mem_we_w[g]),
      .mem_wdata  (mem_wdata_w[g])
    );
  end

  // Memory models: data appears RD_LATENCY cycles after mem_re, random junk otherwise.
  logic [63:0] mem_m [2][16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [63:0] pl_data = 64'd0;
  logic [1:0]  re_sr1 = 2'b00;
  logic [3:0]  idx_sr1 [2];
  logic [1:0]  due_w;
  logic [3:0]  due_idx [2];
  int          wr_cnt [2] = '{0, 0};
  int          rd_cnt [2] = '{0, 0};
  logic [60:0] wr_idx [2];
  logic [60:0] rd_idx [2];
  logic [63:0] wr_log [2][8];
  int          ovl = 0;
  int          cyc = 0;

  assign due_w      = {re_sr1[1], mem_re_w[0]};
  assign due_idx[0] = mem_addr_w[0][3:0];
  assign due_idx[1] = idx_sr1[1];

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    re_sr1     <= {re_sr1[0], mem_re_w[1]};
    idx_sr1[0] <= mem_addr_w[1][3:0];
    idx_sr1[1] <= idx_sr1[0];
    for (int g = 0; g < 2; g++) begin
      if (pl_en) mem_m[g][pl_idx] <= pl_data;
      if (mem_we_w[g]) begin
        mem_m[g][mem_addr_w[g][3:0]] <= mem_wdata_w[g];
        wr_log[g][wr_cnt[g] % 8]     <= mem_wdata_w[g];
        wr_cnt[g]                    <= wr_cnt[g] + 1;
        wr_idx[g]                    <= mem_addr_w[g];
      end
      if (mem_re_w[g]) begin
        rd_cnt[g] <= rd_cnt[g] + 1;
        rd_idx[g] <= mem_addr_w[g];
      end
      if (mem_re_w[g] && mem_we_w[g]) ovl <= ovl + 1;
      mem_rdata_w[g] <= due_w[g] ? mem_m[g][due_idx[g]] : {$urandom, $urandom};
    end
  end

  logic [63:0] ref_mem [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int size_of(input splice_store op);
    case (op)
      SPL_SD:  return 8;
      SPL_SW:  return 4;
      SPL_SH:  return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Little-endian store of sz bytes of wd at byte offset off.
  function automatic logic [63:0] ref_store(input logic [63:0] old, input logic [63:0] wd,
                                            input int sz, input int off);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < sz; k++) r[8*(off+k) +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [63:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (busy_w != 2'b00 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_idle"}, 64'(busy_w), 64'd0);
  endtask

  task automatic run_store(input splice_store op, input logic [6:0] a, input logic [63:0] wd,
                           input string tag);
    int acc, sz, off;
    int lat_d [2];
    int lat_m [2];
    int wr0 [2];
    int rd0 [2];
    logic [3:0]  idx;
    logic        mis;
    logic [63:0] exp_w;
    sz    = size_of(op);
    off   = int'(a[2:0]);
    idx   = a[6:3];
    mis   = (off % sz) != 0;
    exp_w = mis ? ref_mem[idx] : ref_store(ref_mem[idx], wd, sz, off);
    wait_idle(tag);
    for (int g = 0; g < 2; g++) begin
      wr0[g] = wr_cnt[g]; rd0[g] = rd_cnt[g]; lat_d[g] = -1; lat_m[g] = -1;
    end
    start = 1'b1; store_op = 2'(op); addr = 64'(a); wdata = wd; acc = cyc;
    @(negedge clk);
    start = 1'b0; store_op = 2'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    check({tag, "_busy"}, 64'(busy_w), 64'd3);
    for (int c = 0; c < 20; c++) begin
      for (int g = 0; g < 2; g++) begin
        if (done_w[g] && lat_d[g] < 0) lat_d[g] = cyc - acc;
        if (mis_w[g] && lat_m[g] < 0) lat_m[g] = cyc - acc;
      end
      if ((lat_d[0] >= 0 || lat_m[0] >= 0) && (lat_d[1] >= 0 || lat_m[1] >= 0)) break;
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_g%0d_done_lat", tag, g), 64'(lat_d[g]),
            64'(mis ? -1 : (op == SPL_SD ? 2 : 4 + lat_of(g))));
      check($sformatf("%s_g%0d_mis_lat", tag, g), 64'(lat_m[g]), 64'(mis ? 1 : -1));
      check($sformatf("%s_g%0d_writes", tag, g), 64'(wr_cnt[g] - wr0[g]), 64'(mis ? 0 : 1));
      check($sformatf("%s_g%0d_reads", tag, g), 64'(rd_cnt[g] - rd0[g]),
            64'((mis || op == SPL_SD) ? 0 : 1));
      if (!mis) check($sformatf("%s_g%0d_wr_idx", tag, g), 64'(wr_idx[g]), 64'(idx));
      if (!mis && op != SPL_SD) check($sformatf("%s_g%0d_rd_idx", tag, g), 64'(rd_idx[g]), 64'(idx));
      check($sformatf("%s_g%0d_mem", tag, g), mem_m[g][idx], exp_w);
    end
    ref_mem[idx] = exp_w;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0 [2];
    logic [63:0] d1, d2;
    int acc;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_g%0d_ctl", g),
            64'({busy_w[g], done_w[g], mis_w[g], mem_re_w[g], mem_we_w[g]}), 64'd0);
      check($sformatf("rst_g%0d_addr", g), 64'(mem_addr_w[g]), 64'd0);
      check($sformatf("rst_g%0d_wdata", g), mem_wdata_w[g], 64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) preload(4'(i), {$urandom, $urandom});

    run_store(SPL_SD, 7'h10, 64'h1122334455667788, "sd");
    for (int g = 0; g < 2; g++) check($sformatf("sd_g%0d_word", g), mem_m[g][2], 64'h1122334455667788);

    preload(4'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_store(SPL_SB, 7'h0B, 64'h0000_0000_0000_00AB, "sb");
    for (int g = 0; g < 2; g++) check($sformatf("sb_g%0d_word", g), mem_m[g][1], 64'hFFFFFFFFABFFFFFF);

    preload(4'd0, 64'h0123_4567_89AB_CDEF);
    run_store(SPL_SW, 7'h04, 64'hDEAD_BEEF_CAFE_F00D, "sw4");
    for (int g = 0; g < 2; g++) check($sformatf("sw4_g%0d_word", g), mem_m[g][0], 64'hCAFEF00D89ABCDEF);

    run_store(SPL_SW, 7'h02, 64'h1357_9BDF_2468_ACE0, "sw2");
    @(negedge clk);
    check("sw2_busy_drop", 64'(busy_w), 64'd0);

    preload(4'd6, 64'h0011_2233_4455_6677);
    run_store(SPL_SH, 7'h36, 64'hFFFF_FFFF_FFFF_1234, "sh6");
    for (int g = 0; g < 2; g++) check($sformatf("sh6_g%0d_word", g), mem_m[g][6], 64'h1234223344556677);

    // start held high: one accept per store, the second one only after DONE
    d1 = {$urandom, $urandom};
    d2 = ~d1;
    wait_idle("hold");
    for (int g = 0; g < 2; g++) w0[g] = wr_cnt[g];
    start = 1'b1; store_op = 2'(SPL_SD); addr = 64'h18; wdata = d1; acc = cyc;
    @(negedge clk); wdata = d2;
    @(negedge clk); check("hold_done1", 64'(done_w), 64'd3);
    @(negedge clk); check("hold_idle_gap", 64'(busy_w), 64'd0);
    @(negedge clk); start = 1'b0; check("hold_busy2", 64'(busy_w), 64'd3);
    @(negedge clk); check("hold_done2", 64'(done_w), 64'd3);
    check("hold_done2_lat", 64'(cyc - acc), 64'd5);
    @(negedge clk); check("hold_end", 64'(busy_w), 64'd0);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("hold_g%0d_writes", g), 64'(wr_cnt[g] - w0[g]), 64'd2);
      check($sformatf("hold_g%0d_first", g), wr_log[g][w0[g] % 8], d1);
      check($sformatf("hold_g%0d_second", g), wr_log[g][(w0[g] + 1) % 8], d2);
      check($sformatf("hold_g%0d_mem", g), mem_m[g][3], d2);
    end
    ref_mem[3] = d2;

    // asynchronous reset while waiting for read data drops the store
    wait_idle("rstw");
    for (int g = 0; g < 2; g++) w0[g] = wr_cnt[g];
    start = 1'b1; store_op = 2'(SPL_SB); addr = 64'h21; wdata = {$urandom, $urandom};
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rstw_g%0d_ctl", g),
            64'({busy_w[g], done_w[g], mis_w[g], mem_re_w[g], mem_we_w[g]}), 64'd0);
      check($sformatf("rstw_g%0d_addr", g), 64'(mem_addr_w[g]), 64'd0);
      check($sformatf("rstw_g%0d_wdata", g), mem_wdata_w[g], 64'd0);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rstw_g%0d_nowrite", g), 64'(wr_cnt[g] - w0[g]), 64'd0);
      check($sformatf("rstw_g%0d_mem", g), mem_m[g][4], ref_mem[4]);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_store(SPL_SB, 7'h21, {$urandom, $urandom}, "post_rst");

    for (int i = 0; i < 40; i++) begin
      run_store(splice_store'(2'($urandom_range(0, 3))), 7'($urandom_range(0, 127)),
                {$urandom, $urandom}, $sformatf("rnd%0d", i));
    end

    check("re_we_overlap", 64'(ovl), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
